// File: rtl/fb_pkg.sv
// Shared definitions for the zoom framebuffer writer: default geometry,
// FSM state encoding and zoom mode encoding.
package fb_pkg;

  localparam int FB_IMG_W   = 160;
  localparam int FB_IMG_H   = 120;
  localparam int FB_ADDR_W  = 19;
  localparam int FB_COORD_W = 12;
  localparam int FB_DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_t;

  typedef enum logic {
    MODE_1X = 1'b0,
    MODE_2X = 1'b1
  } fb_mode_t;

  // A new fill may only begin from a quiescent state.
  function automatic logic fb_can_start(fb_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Delays the write strobe and destination address to line up with the ROM's
// read latency, and qualifies the ROM data with the delayed strobe.
module fb_delay_line
  import fb_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int AW    = FB_ADDR_W,
  parameter int DW    = FB_DATA_W
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0][AW-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];
  // The ROM itself supplies the data delay; only gate it to the valid window.
  assign o_data  = r_valid[DEPTH-1] ? i_data : '0;

endmodule

// File: rtl/fb_zoom_writer.sv
// Fills a framebuffer from a source ROM at 1x or 2x nearest-neighbour zoom,
// one destination pixel per clock, using only incremental address counters.
module fb_zoom_writer
  import fb_pkg::*;
#(
  parameter int IMG_W   = FB_IMG_W,
  parameter int IMG_H   = FB_IMG_H,
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int ROM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_switch,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [ADDR_W-1:0] o_ram_wraddr,
  output logic [7:0]        o_ram_data,
  output logic              o_ram_wren,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [FB_COORD_W-1:0] L_DW1_M1   = FB_COORD_W'(IMG_W - 1);
  localparam logic [FB_COORD_W-1:0] L_DH1_M1   = FB_COORD_W'(IMG_H - 1);
  localparam logic [FB_COORD_W-1:0] L_DW2_M1   = FB_COORD_W'(2 * IMG_W - 1);
  localparam logic [FB_COORD_W-1:0] L_DH2_M1   = FB_COORD_W'(2 * IMG_H - 1);
  localparam logic [FB_COORD_W-1:0] L_ONE_C    = FB_COORD_W'(1);
  localparam logic [ADDR_W-1:0]     L_ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]     L_ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [1:0]            L_DRAIN_LAST = 2'(ROM_LAT - 1);

  fb_state_t               r_state;
  fb_state_t               w_state_next;
  fb_mode_t                r_mode;
  logic [FB_COORD_W-1:0]   r_dx;
  logic [FB_COORD_W-1:0]   r_dy;
  logic                    r_xph;
  logic                    r_yph;
  logic [ADDR_W-1:0]       r_sx;
  logic [ADDR_W-1:0]       r_row_base;
  logic [ADDR_W-1:0]       r_dst_addr;
  logic [1:0]              r_drain_cnt;

  logic                    w_zoom;
  logic [FB_COORD_W-1:0]   w_dw_m1;
  logic [FB_COORD_W-1:0]   w_dh_m1;
  logic                    w_last_x;
  logic                    w_last_pix;
  logic                    w_issue;
  logic                    w_accept;

  assign w_zoom     = (r_mode == MODE_2X);
  assign w_dw_m1    = w_zoom ? L_DW2_M1 : L_DW1_M1;
  assign w_dh_m1    = w_zoom ? L_DH2_M1 : L_DH1_M1;
  assign w_last_x   = (r_dx == w_dw_m1);
  assign w_last_pix = w_last_x && (r_dy == w_dh_m1);
  assign w_issue    = (r_state == ST_RUN);
  assign w_accept   = i_start && fb_can_start(r_state);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_RUN;
      ST_RUN:   if (w_last_pix) w_state_next = ST_DRAIN;
      ST_DRAIN: if (r_drain_cnt == L_DRAIN_LAST) w_state_next = ST_DONE;
      ST_DONE:  if (i_start) w_state_next = ST_RUN;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 2'd1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Phase bits mark the second copy of a replicated column/row in 2x mode;
  // the source column/row only advances after that second copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= MODE_1X;
      r_dx       <= '0;
      r_dy       <= '0;
      r_xph      <= 1'b0;
      r_yph      <= 1'b0;
      r_sx       <= '0;
      r_row_base <= '0;
      r_dst_addr <= '0;
    end else if (w_accept) begin
      r_mode     <= fb_mode_t'(i_switch);
      r_dx       <= '0;
      r_dy       <= '0;
      r_xph      <= 1'b0;
      r_yph      <= 1'b0;
      r_sx       <= '0;
      r_row_base <= '0;
      r_dst_addr <= '0;
    end else if (w_issue) begin
      r_dst_addr <= r_dst_addr + L_ONE_A;
      if (w_last_x) begin
        r_dx  <= '0;
        r_sx  <= '0;
        r_xph <= 1'b0;
        r_dy  <= r_dy + L_ONE_C;
        r_yph <= w_zoom & ~r_yph;
        if (!w_zoom || r_yph) begin
          r_row_base <= r_row_base + L_ROW_STEP;
        end
      end else begin
        r_dx  <= r_dx + L_ONE_C;
        r_xph <= w_zoom & ~r_xph;
        if (!w_zoom || r_xph) begin
          r_sx <= r_sx + L_ONE_A;
        end
      end
    end
  end

  assign o_rom_addr = w_issue ? (r_row_base + r_sx) : '0;
  assign o_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done     = (r_state == ST_DONE);

  fb_delay_line #(
    .DEPTH (ROM_LAT),
    .AW    (ADDR_W),
    .DW    (8)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (w_issue),
    .i_addr  (r_dst_addr),
    .i_data  (i_rom_data),
    .o_valid (o_ram_wren),
    .o_addr  (o_ram_wraddr),
    .o_data  (o_ram_data)
  );

endmodule

// File: tb/tb_fb_zoom_writer.sv
// Directed bench for fb_zoom_writer: a 1-cycle-latency and a 3-cycle-latency
// instance on a reduced 20x15 image, each fed by its own ROM model.
module tb_fb_zoom_writer;
  import fb_pkg::*;

  localparam int W  = 20;
  localparam int H  = 15;
  localparam int AW = 19;
  localparam int N1 = W * H;
  localparam int N2 = 4 * W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sw = 1'b0;

  logic [AW-1:0] rom_addr_a, rom_addr_b, wraddr_a, wraddr_b;
  logic [7:0]    rom_data_a, rom_data_b, wdata_a, wdata_b;
  logic          wren_a, wren_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  fb_zoom_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .ROM_LAT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_switch(sw),
    .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a),
    .o_ram_wraddr(wraddr_a), .o_ram_data(wdata_a), .o_ram_wren(wren_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  fb_zoom_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .ROM_LAT(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_switch(sw),
    .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
    .o_ram_wraddr(wraddr_b), .o_ram_data(wdata_b), .o_ram_wren(wren_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  // ROM models: data = addr[7:0], with 1 and 3 cycles of read latency.
  logic [AW-1:0] qa, qb0, qb1, qb2;
  always @(posedge clk) begin
    qa  <= rom_addr_a;
    qb0 <= rom_addr_b;
    qb1 <= qb0;
    qb2 <= qb1;
  end
  assign rom_data_a = qa[7:0];
  assign rom_data_b = qb2[7:0];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int exp_f = 1;
  int wr_cnt[2];
  int first_cyc[2];
  int last_cyc[2];
  int done_cyc[2];
  logic [7:0] fbm[2][N2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_pix(int idx, int f);
    int dw, dx, dy, src;
    dw  = W * f;
    dx  = idx % dw;
    dy  = idx / dw;
    src = (dy / f) * W + dx / f;
    return src[7:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mon(int u, logic wren, logic [AW-1:0] wa, logic [7:0] wd, logic busy, logic done);
    logic [7:0] exp_d;
    if (wren === 1'b1) begin
      exp_d = model_pix(wr_cnt[u], exp_f);
      checks++;
      assert (busy === 1'b1) else begin
        failures++;
        $error("FAIL wren_outside_busy u=%0d observed=%b expected=1", u, busy);
      end
      checks++;
      assert (wa === AW'(wr_cnt[u])) else begin
        failures++;
        $error("FAIL wraddr u=%0d idx=%0d observed=%0d expected=%0d", u, wr_cnt[u], wa, wr_cnt[u]);
      end
      checks++;
      assert (wd === exp_d) else begin
        failures++;
        $error("FAIL wdata u=%0d idx=%0d observed=%0d expected=%0d", u, wr_cnt[u], wd, exp_d);
      end
      if (wr_cnt[u] == 0) first_cyc[u] = cyc;
      last_cyc[u] = cyc;
      if (!$isunknown(wa) && wa < AW'(N2)) fbm[u][int'(wa)] = wd;
      wr_cnt[u]++;
    end
    if (done === 1'b1 && done_cyc[u] < 0) done_cyc[u] = cyc;
  endtask

  always @(negedge clk) begin
    mon(0, wren_a, wraddr_a, wdata_a, busy_a, done_a);
    mon(1, wren_b, wraddr_b, wdata_b, busy_b, done_b);
  end

  task automatic arm();
    for (int u = 0; u < 2; u++) begin
      wr_cnt[u] = 0;
      first_cyc[u] = -1;
      last_cyc[u] = -1;
      done_cyc[u] = -1;
    end
  endtask

  // t0 = cycle count seen right after the edge that accepts start.
  task automatic pulse_start();
    @(negedge clk);
    #1 arm();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (done_a === 1'b1 && done_b === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("done_reached", {30'd0, done_a, done_b}, 32'd3);
  endtask

  task automatic check_fill(string name, int n);
    int lat;
    for (int u = 0; u < 2; u++) begin
      lat = (u == 0) ? 1 : 3;
      chk($sformatf("%s_writes_u%0d", name, u), wr_cnt[u], n);
      chk($sformatf("%s_first_u%0d", name, u), first_cyc[u], t0 + lat);
      chk($sformatf("%s_last_u%0d", name, u), last_cyc[u], t0 + n - 1 + lat);
      chk($sformatf("%s_done_u%0d", name, u), done_cyc[u], t0 + n + lat);
      $display("fill %s u=%0d lat=%0d writes=%0d first=%0d last=%0d done=%0d t0=%0d",
               name, u, lat, wr_cnt[u], first_cyc[u], last_cyc[u], done_cyc[u], t0);
    end
  endtask

  task automatic check_all_zero(string name);
    chk({name, "_wren"}, {30'd0, wren_a, wren_b}, 32'd0);
    chk({name, "_busy"}, {30'd0, busy_a, busy_b}, 32'd0);
    chk({name, "_done"}, {30'd0, done_a, done_b}, 32'd0);
    chk({name, "_rom_addr_a"}, rom_addr_a, 32'd0);
    chk({name, "_rom_addr_b"}, rom_addr_b, 32'd0);
    chk({name, "_wraddr_a"}, wraddr_a, 32'd0);
    chk({name, "_wraddr_b"}, wraddr_b, 32'd0);
    chk({name, "_wdata"}, {wdata_a, wdata_b}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    arm();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // 1x fill
    exp_f = 1;
    sw = 1'b0;
    pulse_start();
    chk("run1x_busy", {30'd0, busy_a, busy_b}, 32'd3);
    wait_done();
    check_fill("f1x", N1);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("f1x_px0_u%0d", u), fbm[u][0], 32'd0);
      chk($sformatf("f1x_px21_u%0d", u), fbm[u][21], 32'd21);
      chk($sformatf("f1x_px299_u%0d", u), fbm[u][299], 32'd43);
    end

    // restart from DONE in 2x; a mid-run start with switch toggled is ignored
    exp_f = 2;
    sw = 1'b1;
    pulse_start();
    chk("restart_done_cleared", {30'd0, done_a, done_b}, 32'd0);
    chk("restart_busy", {30'd0, busy_a, busy_b}, 32'd3);
    repeat (100) @(negedge clk);
    #1 sw = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("midrun_start_busy", {30'd0, busy_a, busy_b}, 32'd3);
    wait_done();
    check_fill("f2x", N2);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("f2x_px0_u%0d", u), fbm[u][0], 32'd0);
      chk($sformatf("f2x_px1_u%0d", u), fbm[u][1], 32'd0);
      chk($sformatf("f2x_px40_u%0d", u), fbm[u][40], 32'd0);
      chk($sformatf("f2x_px41_u%0d", u), fbm[u][41], 32'd0);
      chk($sformatf("f2x_px42_u%0d", u), fbm[u][42], 32'd1);
      chk($sformatf("f2x_px80_u%0d", u), fbm[u][80], 32'd20);
      chk($sformatf("f2x_px1199_u%0d", u), fbm[u][1199], 32'd43);
    end

    // reset in the middle of a 1x fill
    exp_f = 1;
    sw = 1'b0;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (wr_cnt[0] >= 20) break;
      @(negedge clk);
    end
    chk("abort_reached_20", {31'd0, wr_cnt[0] >= 20}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("abort");
    snap = wr_cnt[0] + wr_cnt[1];
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("abort_no_writes", wr_cnt[0] + wr_cnt[1], snap);
    check_all_zero("abort_idle");
    $display("abort writes_a=%0d writes_b=%0d", wr_cnt[0], wr_cnt[1]);

    // fresh 1x fill after the abort
    pulse_start();
    wait_done();
    check_fill("f1x_again", N1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_zoom_writer.md
FB_ZOOM_WRITER -- requirements
Module: fb_zoom_writer

Interface
REQ-001 Parameter IMG_W, default 160, source image width in pixels.
REQ-002 Parameter IMG_H, default 120, source image height in pixels.
REQ-003 Parameter ADDR_W, default 19, ROM and framebuffer address width.
REQ-004 Parameter ROM_LAT, default 1, cycles from rom_addr to valid rom_data (1..3).
REQ-005 Port: clock, input, 1, sole clock (25 MHz VGA domain).
REQ-006 Port: reset, input, 1, asynchronous, active-low.
REQ-007 Port: start, input, 1, one-cycle request to (re)fill the framebuffer.
REQ-008 Port: switch, input, 1, zoom select: 0 = 1x (160x120), 1 = 2x (320x240).
REQ-009 Port: rom_addr, output, ADDR_W, source pixel address.
REQ-010 Port: rom_data, input, 8, grayscale source pixel.
REQ-011 Port: ram_wraddr, output, ADDR_W, framebuffer write address.
REQ-012 Port: ram_data, output, 8, framebuffer write data.
REQ-013 Port: ram_wren, output, 1, framebuffer write strobe.
REQ-014 Port: busy, output, 1, high from start acceptance until the last write.
REQ-015 Port: done, output, 1, high after a completed fill until the next accepted start.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-017 start SHALL be accepted only in IDLE or DONE; start in RUN/DRAIN is ignored.
REQ-018 On acceptance, switch SHALL be latched into a mode register (F = 1 or 2); later switch changes do not affect the fill in progress.
REQ-019 Destination size: DW = IMG_W*F, DH = IMG_H*F; pixel count N = DW*DH (19200 or 76800).
REQ-020 In RUN, one destination pixel (dx,dy) SHALL be issued per cycle, raster order, dx fastest, starting at (0,0).
REQ-021 For each issued pixel, rom_addr = (dy/F)*IMG_W + (dx/F) (nearest-neighbour replication).
REQ-022 Exactly ROM_LAT cycles after issue: ram_wren = 1, ram_wraddr = dy*DW + dx, ram_data = rom_data.
REQ-023 Addresses SHALL be generated with incremental counters/adders; no multipliers.
REQ-024 After pixel N-1 is issued, the FSM SHALL enter DRAIN for ROM_LAT cycles, then DONE.
REQ-025 Start accepted at edge k: first ram_wren at cycle k+1+ROM_LAT; last write at k+N+ROM_LAT; done rises at k+N+ROM_LAT+1.
REQ-026 ram_wren SHALL be high exactly N cycles per fill, contiguous, never outside RUN/DRAIN.
REQ-027 busy SHALL equal (state == RUN or DRAIN); done SHALL equal (state == DONE).
REQ-028 Start accepted in DONE SHALL clear done on the next cycle and restart from (0,0).
REQ-029 rom_addr SHALL hold 0 when no pixel is issued.

Reset
REQ-030 Reset low SHALL immediately force IDLE, clear all counters, pipeline valids and mode register.
REQ-031 Reset values: rom_addr 0, ram_wraddr 0, ram_data 0, ram_wren 0, busy 0, done 0.
REQ-032 Reset mid-fill SHALL abort with no further writes; the fill restarts only on a new start.

Structure
REQ-033 State encoding and IMG_W/IMG_H/ADDR_W defaults SHALL live in a shared package, fb_pkg.
REQ-034 The ROM_LAT-deep valid/address/data delay line SHALL be a sub-module, fb_delay_line.

Verification
REQ-035 switch=0, start pulse, ROM model data=addr[7:0] -> 19200 writes, wraddr 0..19199 sequential, data[i]=i[7:0], done after 19200+ROM_LAT+1 cycles.
REQ-036 switch=1, start -> 76800 writes; wraddr 0,1 and 320,321 all carry rom_addr 0; wraddr 76799 carries rom_addr 19199.
REQ-037 Toggle switch and pulse start mid-RUN -> ignored, mode and write count unchanged.
REQ-038 Assert reset at write 5000 -> ram_wren 0 immediately, all outputs 0, no writes until next start.
REQ-039 start in DONE with switch=1 after a 1x fill -> done drops next cycle, full 2x fill follows.
REQ-040 ROM_LAT=1 and ROM_LAT=3 builds -> first-write and done timing per REQ-025, data aligned.
